// File: rtl/reg_scan_ctrl_pkg.sv
// Shared types and constants for the register-file scan controller.
package reg_scan_pkg;

   localparam int SCAN_W = 8;   // register-file data width
   localparam int SCAN_D = 4;   // register-file index width (2**SCAN_D entries)

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DUMP_RD  = 2'd1,
      DUMP_OUT = 2'd2,
      LOAD     = 2'd3
   } scan_state_t;

   localparam logic OP_DUMP = 1'b0;
   localparam logic OP_LOAD = 1'b1;

   // Top two entries: a protected register and the hard-wired zero register.
   localparam logic [SCAN_D-1:0] PROT_REG = SCAN_D'(2**SCAN_D - 2);
   localparam logic [SCAN_D-1:0] ZERO_REG = SCAN_D'(2**SCAN_D - 1);

   // Loads to these indices still consume a stream word but never write.
   function automatic logic is_write_blocked(input logic [SCAN_D-1:0] idx);
      return (idx == PROT_REG) || (idx == ZERO_REG);
   endfunction

endpackage

// File: rtl/reg_scan_ctrl_if.sv
// Command, stream and register-file port bundle for the scan controller.
// master = the controller, slave = harness plus register file.
interface reg_scan_ctrl_if
   import reg_scan_pkg::*;
#(
   parameter int W = SCAN_W,
   parameter int D = SCAN_D
) ();

   // command channel
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_op;
   logic         busy;
   logic         done;

   // register-file ports
   logic [D-1:0] rf_src;
   logic [W-1:0] rf_rdata;
   logic         rf_we;
   logic [D-1:0] rf_waddr;
   logic [W-1:0] rf_wdata;

   // dump stream
   logic         dout_valid;
   logic         dout_ready;
   logic [W-1:0] dout_data;
   logic         dout_last;

   // load stream
   logic         din_valid;
   logic         din_ready;
   logic [W-1:0] din_data;

   modport master (
      input  cmd_valid, cmd_op, rf_rdata, dout_ready, din_valid, din_data,
      output cmd_ready, busy, done, rf_src, rf_we, rf_waddr, rf_wdata,
             dout_valid, dout_data, dout_last, din_ready
   );

   modport slave (
      output cmd_valid, cmd_op, rf_rdata, dout_ready, din_valid, din_data,
      input  cmd_ready, busy, done, rf_src, rf_we, rf_waddr, rf_wdata,
             dout_valid, dout_data, dout_last, din_ready
   );

endinterface

// File: rtl/reg_scan_ctrl.sv
// Scan controller: dumps every register-file entry onto a valid/ready stream
// or loads every entry from one, taking over the register-file ports while busy.
module reg_scan_ctrl
   import reg_scan_pkg::*;
(
   input  logic            CLK,
   input  logic            RESETn,
   reg_scan_ctrl_if.master bus
);

   localparam int W = SCAN_W;
   localparam int D = SCAN_D;
   localparam logic [D-1:0] LAST_IDX = ZERO_REG;

   scan_state_t  state_reg, state_next;
   logic [D-1:0] idx_reg, idx_next;
   logic [W-1:0] dout_data_reg, dout_data_next;
   logic         dout_last_reg, dout_last_next;
   logic         dout_valid_reg, dout_valid_next;
   logic         done_reg, done_next;

   logic         cmd_ready;
   logic         busy;
   logic         din_ready;
   logic         rf_we;
   logic [D-1:0] rf_src;
   logic [D-1:0] rf_waddr;
   logic [W-1:0] rf_wdata;

   // Next-state, counter and output decode for the scan FSM.
   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      dout_data_next  = dout_data_reg;
      dout_last_next  = dout_last_reg;
      dout_valid_next = dout_valid_reg;
      done_next       = 1'b0;
      cmd_ready       = 1'b0;
      busy            = 1'b1;
      din_ready       = 1'b0;
      rf_we           = 1'b0;
      rf_src          = '0;
      rf_waddr        = '0;
      rf_wdata        = '0;

      unique case (state_reg)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (bus.cmd_valid) begin
               idx_next = '0;
               if (bus.cmd_op == OP_LOAD) begin
                  state_next = LOAD;
               end else begin
                  state_next = DUMP_RD;
               end
            end
         end

         DUMP_RD: begin
            // Register-file read is combinational; capture it into the output slot.
            rf_src          = idx_reg;
            dout_data_next  = bus.rf_rdata;
            dout_last_next  = (idx_reg == LAST_IDX);
            dout_valid_next = 1'b1;
            state_next      = DUMP_OUT;
         end

         DUMP_OUT: begin
            rf_src = idx_reg;
            if (bus.dout_ready) begin
               dout_valid_next = 1'b0;
               if (idx_reg == LAST_IDX) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  idx_next   = idx_reg + D'(1);
                  state_next = DUMP_RD;
               end
            end
         end

         LOAD: begin
            din_ready = 1'b1;
            rf_waddr  = idx_reg;
            rf_wdata  = bus.din_data;
            rf_we     = bus.din_valid && !is_write_blocked(idx_reg);
            if (bus.din_valid) begin
               if (idx_reg == LAST_IDX) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  idx_next = idx_reg + D'(1);
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, index and registered stream outputs; reset clears everything at once.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         dout_data_reg  <= '0;
         dout_last_reg  <= 1'b0;
         dout_valid_reg <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         dout_data_reg  <= dout_data_next;
         dout_last_reg  <= dout_last_next;
         dout_valid_reg <= dout_valid_next;
         done_reg       <= done_next;
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.busy       = busy;
   assign bus.done       = done_reg;
   assign bus.rf_src     = rf_src;
   assign bus.rf_we      = rf_we;
   assign bus.rf_waddr   = rf_waddr;
   assign bus.rf_wdata   = rf_wdata;
   assign bus.dout_valid = dout_valid_reg;
   assign bus.dout_data  = dout_data_reg;
   assign bus.dout_last  = dout_last_reg;
   assign bus.din_ready  = din_ready;

endmodule
